seg7_scan_driver: RTL and testbench

//  Time-multiplexes the 28-bit, 4-digit segment code from the binary-to-7seg stage onto one

---
 rtl/seg7_scan_driver.sv | 103 ++++++++++
 tb/tb_seg7_scan_driver.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit active-low 7-segment driver with per-frame code latch and dead time.
// Optional LEADING_ZERO_BLANK_EN: blanks leading zeros of hundreds/tens when the frame is latched.
module seg7_scan_driver #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned DEAD_CYCLES = 16,
    parameter logic [6:0]  ZERO_CODE   = 7'b1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [27:0] code,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_END  = CNT_W'(DEAD_CYCLES);

    logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [1:0]       digit_idx_q, digit_idx_d;
    logic [27:0]      shadow_q, shadow_d;
    logic             first_q;
    logic [6:0]       seg_d;
    logic [3:0]       an_d;
    logic             tick_d;
    logic             slot_wrap;
    logic             frame_start;

    function automatic logic [27:0] frame_code(input logic [27:0] c);
        logic [27:0] r;
        r = c;
`ifdef LEADING_ZERO_BLANK_EN
        if (c[20:14] == ZERO_CODE) begin
            r[20:14] = 7'h7F;
            if (c[13:7] == ZERO_CODE) begin
                r[13:7] = 7'h7F;
            end
        end
`endif
        return r;
    endfunction

    assign slot_wrap   = (slot_cnt_q == SLOT_LAST);
    assign frame_start = first_q || (slot_wrap && (digit_idx_q == 2'd3));

    always_comb begin
        slot_cnt_d  = slot_cnt_q;
        digit_idx_d = digit_idx_q;
        shadow_d    = shadow_q;
        tick_d      = 1'b0;
        seg_d       = 7'h7F;
        an_d        = 4'hF;

        // The first cycle after reset release is itself a frame boundary; hold the
        // counters there so the new frame starts at slot 0 of digit 0.
        if (first_q) begin
            slot_cnt_d  = '0;
            digit_idx_d = 2'd0;
        end else if (slot_wrap) begin
            slot_cnt_d  = '0;
            digit_idx_d = digit_idx_q + 2'd1;
        end else begin
            slot_cnt_d = slot_cnt_q + 1'b1;
        end

        if (frame_start) begin
            shadow_d = frame_code(code);
            tick_d   = 1'b1;
        end

        if (slot_cnt_q >= DEAD_END) begin
            unique case (digit_idx_q)
                2'd0: begin an_d = 4'b1110; seg_d = shadow_q[6:0];   end
                2'd1: begin an_d = 4'b1101; seg_d = shadow_q[13:7];  end
                2'd2: begin an_d = 4'b1011; seg_d = shadow_q[20:14]; end
                2'd3: begin an_d = 4'b0111; seg_d = shadow_q[27:21]; end
                default: begin an_d = 4'hF; seg_d = 7'h7F; end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_cnt_q  <= '0;
            digit_idx_q <= 2'd0;
            shadow_q    <= 28'hFFFFFFF;
            first_q     <= 1'b1;
            seg         <= 7'h7F;
            an          <= 4'hF;
            frame_tick  <= 1'b0;
        end else begin
            slot_cnt_q  <= slot_cnt_d;
            digit_idx_q <= digit_idx_d;
            shadow_q    <= shadow_d;
            first_q     <= 1'b0;
            seg         <= seg_d;
            an          <= an_d;
            frame_tick  <= tick_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized self-checking bench for seg7_scan_driver against a frame-position model.
// Honours LEADING_ZERO_BLANK_EN the same way the design does.
module tb_seg7_scan_driver;

    localparam int R = 8;
    localparam int D = 2;
    localparam logic [6:0] ZC = 7'b1000000;

    logic        clk;
    logic        rst_n;
    logic [27:0] code;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    seg7_scan_driver #(
        .REFRESH_DIV(R),
        .DEAD_CYCLES(D),
        .ZERO_CODE  (ZC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .code      (code),
        .seg       (seg),
        .an        (an),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: k counts released clock edges; scan position p = k-1 cycles into the scan.
    int          k = 0;
    logic [27:0] m_shadow = 28'hFFFFFFF;
    logic [6:0]  e_seg = 7'h7F;
    logic [3:0]  e_an = 4'hF;
    logic        e_tick = 1'b0;
    bit          m_valid = 1'b0;

    function automatic logic [27:0] model_latch(input logic [27:0] c);
        logic [6:0] dg [4];
        for (int i = 0; i < 4; i++) dg[i] = c[7*i +: 7];
`ifdef LEADING_ZERO_BLANK_EN
        if (dg[2] == ZC) begin
            dg[2] = 7'h7F;
            if (dg[1] == ZC) dg[1] = 7'h7F;
        end
`endif
        return {dg[3], dg[2], dg[1], dg[0]};
    endfunction

    always @(posedge clk) begin
        int ps, pd;
        if (!rst_n) begin
            k        = 0;
            m_shadow = 28'hFFFFFFF;
            e_seg    = 7'h7F;
            e_an     = 4'hF;
            e_tick   = 1'b0;
        end else begin
            k++;
            // Outputs show the state that held during the previous cycle.
            if (k == 1) begin
                ps = 0;
                pd = 0;
            end else begin
                ps = (k - 2) % R;
                pd = ((k - 2) / R) % 4;
            end
            if (ps < D) begin
                e_an  = 4'hF;
                e_seg = 7'h7F;
            end else begin
                e_an  = ~(4'b0001 << pd);
                e_seg = m_shadow[7*pd +: 7];
            end
            e_tick = (((k - 1) % (4 * R)) == 0);
            if (e_tick) m_shadow = model_latch(code);
        end
        m_valid = 1'b1;
    end

    logic [6:0] prev_seg = 7'h7F;
    logic [3:0] prev_an = 4'hF;

    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if (seg !== e_seg || an !== e_an || frame_tick !== e_tick) begin
                errors++;
                $display("FAIL model t=%0t got seg=%h an=%b tick=%b want seg=%h an=%b tick=%b",
                         $time, seg, an, frame_tick, e_seg, e_an, e_tick);
            end
            checks++;
            if ($countones(~an) > 1) begin
                errors++;
                $display("FAIL one_anode t=%0t got an=%b want at most one low", $time, an);
            end
            if (an != 4'hF && an == prev_an) begin
                checks++;
                if (seg != prev_seg) begin
                    errors++;
                    $display("FAIL seg_stable t=%0t got seg=%h want %h while an=%b",
                             $time, seg, prev_seg, an);
                end
            end
            prev_seg = seg;
            prev_an  = an;
        end
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (frame_tick) begin
                ok = 1'b1;
                break;
            end
        end
        chk("tick_timeout", int'(ok), 1);
    endtask

    // Waits for a frame tick, disturbs code, then records seg per lit anode over one frame.
    task automatic capture_frame(output logic [6:0] s [4]);
        bit ok;
        for (int i = 0; i < 4; i++) s[i] = 7'h00;
        wait_tick(ok);
        code = $urandom;
        for (int c = 0; c < 4 * R; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) if (an == ~(4'b0001 << i)) s[i] = seg;
        end
    endtask

    initial begin
        logic [6:0] s [4];
        bit ok;
        int n, n_on, n_off;

        rst_n = 1'b0;
        code  = {7'h7F, 7'h06, 7'h5B, 7'h4F};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_an", int'(an), 'hF);
            chk("reset_seg", int'(seg), 'h7F);
            chk("reset_tick", int'(frame_tick), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_tick", int'(frame_tick), 1);

        n = 0;
        n_on = 0;
        n_off = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            n++;
            if (an == 4'b1110) n_on++;
            if (an == 4'hF) n_off++;
            if (frame_tick) break;
        end
        chk("tick_period", n, 32);
        chk("an0_low_cycles", n_on, 6);
        chk("dead_cycles", n_off, 8);

        code = {7'h7F, 7'h79, 7'h24, 7'h30};
        capture_frame(s);
        chk("d123_an0", int'(s[0]), 'h30);
        chk("d123_an1", int'(s[1]), 'h24);
        chk("d123_an2", int'(s[2]), 'h79);
        chk("d123_an3", int'(s[3]), 'h7F);

        code = {7'h7F, ZC, ZC, 7'h12};
        capture_frame(s);
        chk("d005_an0", int'(s[0]), 'h12);
`ifdef LEADING_ZERO_BLANK_EN
        chk("d005_an1", int'(s[1]), 'h7F);
        chk("d005_an2", int'(s[2]), 'h7F);
`else
        chk("d005_an1", int'(s[1]), int'(ZC));
        chk("d005_an2", int'(s[2]), int'(ZC));
`endif

        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (an == 4'b1011) begin
                ok = 1'b1;
                break;
            end
        end
        chk("an2_seen", int'(ok), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_an", int'(an), 'hF);
        chk("midreset_seg", int'(seg), 'h7F);
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (an != 4'hF) begin
                ok = 1'b1;
                break;
            end
        end
        chk("restart_an0", int'(an), 'hE);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) begin
                for (int i = 0; i < 4; i++)
                    code[7*i +: 7] = ($urandom_range(0, 1) == 0) ? ZC : 7'($urandom);
            end
            if (rst_n == 1'b0) rst_n = 1'b1;
            else if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
